// File: rtl/axi_llc_sram_req_ctrl.sv
// axi_llc_sram_req_ctrl
// Request controller in front of an LLC SRAM macro. Forwards a valid/ready
// request stream to the SRAM req/gnt port, tracks read latency with a valid
// shift register and captures read data into a response FIFO. Reads are only
// issued when a FIFO entry is reserved (credit = RspDepth - fifo - inflight).
// Optional feature: define AXI_LLC_SRAM_REQ_CTRL_ERR_CNT_EN to build the
// saturating corrected-error counter; otherwise err_cnt_o is tied to 0.
module axi_llc_sram_req_ctrl #(
    parameter int unsigned AddrWidth   = 10,
    parameter int unsigned DataWidth   = 128,
    parameter int unsigned BeWidth     = DataWidth / 8,
    parameter int unsigned Latency     = 1,
    parameter int unsigned RspDepth    = 4,
    parameter int unsigned ErrCntWidth = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic [DataWidth-1:0]   req_wdata_i,
    input  logic [BeWidth-1:0]     req_be_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [DataWidth-1:0]   rsp_rdata_o,
    output logic                   sram_req_o,
    output logic                   sram_we_o,
    output logic [AddrWidth-1:0]   sram_addr_o,
    output logic [DataWidth-1:0]   sram_wdata_o,
    output logic [BeWidth-1:0]     sram_be_o,
    input  logic                   sram_gnt_i,
    input  logic [DataWidth-1:0]   sram_rdata_i,
    input  logic                   sram_single_err_i,
    output logic [ErrCntWidth-1:0] err_cnt_o,
    output logic                   busy_o
);

    localparam int unsigned CntW = $clog2(RspDepth + 1);
    localparam int unsigned PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam logic [CntW:0]   DepthVal = (CntW + 1)'(RspDepth);
    localparam logic [PtrW-1:0] PtrLast  = PtrW'(RspDepth - 1);

    logic [CntW-1:0]      fifo_cnt_q;
    logic [CntW-1:0]      inflight_q;
    logic [CntW:0]        occupancy;
    logic                 eligible;
    logic                 rd_acc;
    logic                 rd_exit;
    logic                 push;
    logic                 pop;
    logic [Latency-1:0]   vld_q;
    logic [Latency-1:0]   vld_d;
    logic [DataWidth-1:0] mem_q [RspDepth];
    logic [PtrW-1:0]      wptr_q;
    logic [PtrW-1:0]      rptr_q;

    // Credits come from registered state only, so rsp_ready_i never reaches req_ready_o
    assign occupancy = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
    assign eligible  = req_we_i | (occupancy < DepthVal);

    assign sram_req_o   = req_valid_i & eligible;
    assign req_ready_o  = sram_gnt_i & eligible;
    assign sram_we_o    = req_we_i;
    assign sram_addr_o  = req_addr_i;
    assign sram_wdata_o = req_wdata_i;
    assign sram_be_o    = req_be_i;

    assign rd_acc  = sram_req_o & sram_gnt_i & ~req_we_i;
    assign rd_exit = vld_q[Latency-1];
    assign push    = rd_exit;
    assign pop     = rsp_valid_o & rsp_ready_i;

    assign rsp_valid_o = (fifo_cnt_q != '0);
    assign rsp_rdata_o = rsp_valid_o ? mem_q[rptr_q] : '0;
    assign busy_o      = (inflight_q != '0) | rsp_valid_o;

    // Next state of the read-latency valid shift register
    always_comb begin
        vld_d    = '0;
        vld_d[0] = rd_acc;
        for (int unsigned i = 1; i < Latency; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    // Latency tracking: shift register and in-flight read count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q      <= '0;
            inflight_q <= '0;
        end else begin
            vld_q      <= vld_d;
            inflight_q <= inflight_q + CntW'(rd_acc) - CntW'(rd_exit);
        end
    end

    // Response FIFO pointers and fill count, pointers wrap modulo RspDepth
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= (wptr_q == PtrLast) ? '0 : wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_q <= (rptr_q == PtrLast) ? '0 : rptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + CntW'(1);
            end else if (!push && pop) begin
                fifo_cnt_q <= fifo_cnt_q - CntW'(1);
            end
        end
    end

    // Response FIFO storage; contents are masked at the output while empty
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= sram_rdata_i;
        end
    end

`ifdef AXI_LLC_SRAM_REQ_CTRL_ERR_CNT_EN
    logic [ErrCntWidth-1:0] err_cnt_q;

    // Saturating count of corrected-error pulses, cleared only by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else if (sram_single_err_i && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ErrCntWidth'(1);
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    logic unused_err;
    assign unused_err = sram_single_err_i;
    assign err_cnt_o  = '0;
`endif

    // Credit scheme must keep reserved storage within the FIFO depth
    assert property (@(posedge clk_i) disable iff (rst_i) occupancy <= DepthVal);

endmodule

// File: tb/tb_axi_llc_sram_req_ctrl.sv
// Testbench for axi_llc_sram_req_ctrl: directed scenarios followed by random
// traffic. Expected responses are queued when a read is accepted and popped
// by an independent monitor that checks every cycle on the falling edge.
module tb_axi_llc_sram_req_ctrl;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 64;
    localparam int unsigned BW    = DW / 8;
    localparam int unsigned LAT   = 1;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned EW    = 3;

    logic          clk_i;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_we_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_wdata_i;
    logic [BW-1:0] req_be_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_rdata_o;
    logic          sram_req_o;
    logic          sram_we_o;
    logic [AW-1:0] sram_addr_o;
    logic [DW-1:0] sram_wdata_o;
    logic [BW-1:0] sram_be_o;
    logic          sram_gnt_i;
    logic [DW-1:0] sram_rdata_i;
    logic          sram_single_err_i;
    logic [EW-1:0] err_cnt_o;
    logic          busy_o;

    axi_llc_sram_req_ctrl #(
        .AddrWidth  (AW),
        .DataWidth  (DW),
        .BeWidth    (BW),
        .Latency    (LAT),
        .RspDepth   (DEPTH),
        .ErrCntWidth(EW)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_we_i         (req_we_i),
        .req_addr_i       (req_addr_i),
        .req_wdata_i      (req_wdata_i),
        .req_be_i         (req_be_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_ready_i      (rsp_ready_i),
        .rsp_rdata_o      (rsp_rdata_o),
        .sram_req_o       (sram_req_o),
        .sram_we_o        (sram_we_o),
        .sram_addr_o      (sram_addr_o),
        .sram_wdata_o     (sram_wdata_o),
        .sram_be_o        (sram_be_o),
        .sram_gnt_i       (sram_gnt_i),
        .sram_rdata_i     (sram_rdata_i),
        .sram_single_err_i(sram_single_err_i),
        .err_cnt_o        (err_cnt_o),
        .busy_o           (busy_o)
    );

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   due;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] ref_mem  [2**AW];
    logic [DW-1:0] sram_mem [2**AW];
    logic [DW-1:0] rpipe    [LAT];
    int unsigned   cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int unsigned   err_pulses = 0;
    bit            rand_en = 0;
    bit            dir_gnt = 1;
    bit            dir_rdy = 1;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    // Behavioural SRAM: byte-enabled writes, reads return data LAT cycles later
    always @(posedge clk_i) begin
        if (sram_req_o && sram_gnt_i && sram_we_o) begin
            for (int unsigned b = 0; b < BW; b++) begin
                if (sram_be_o[b]) sram_mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
            end
        end
        rpipe[0] <= (sram_req_o && sram_gnt_i && !sram_we_o) ? sram_mem[sram_addr_o]
                                                            : {$urandom, $urandom};
        for (int unsigned i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign sram_rdata_i = rpipe[LAT-1];

    // Grant, consumer-ready and error-pulse driver
    initial begin
        sram_gnt_i        = 1'b0;
        rsp_ready_i       = 1'b0;
        sram_single_err_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #3;
            sram_gnt_i        = rand_en ? ($urandom_range(0, 3) != 0) : dir_gnt;
            rsp_ready_i       = rand_en ? ($urandom_range(0, 2) != 0) : dir_rdy;
            sram_single_err_i = ($urandom_range(0, 3) == 0);
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail_bound(input string name, input int unsigned waited);
        checks++;
        errors++;
        $display("FAIL %s: nothing after %0d cycles, required completion at cycle %0d", name, waited, cyc);
    endtask

    function automatic logic [EW-1:0] exp_err();
`ifdef AXI_LLC_SRAM_REQ_CTRL_ERR_CNT_EN
        int unsigned sat;
        sat = (2**EW) - 1;
        return (err_pulses > sat) ? EW'(sat) : EW'(err_pulses);
`else
        return '0;
`endif
    endfunction

    // Monitor: compare every output against the reference, then retire handshakes
    initial begin
        forever begin
            bit room;
            bit head_due;
            @(negedge clk_i);
            if (rst_i) begin
                chk("rst_rsp_valid", 128'(rsp_valid_o), 128'(0));
                chk("rst_rdata",     128'(rsp_rdata_o), 128'(0));
                chk("rst_busy",      128'(busy_o), 128'(0));
                chk("rst_err_cnt",   128'(err_cnt_o), 128'(0));
                chk("rst_req_ready", 128'(req_ready_o), 128'(sram_gnt_i));
                sb.delete();
                err_pulses = 0;
            end else begin
                room     = req_we_i || (sb.size() < DEPTH);
                head_due = (sb.size() != 0) && (sb[0].due <= cyc);
                chk("req_ready", 128'(req_ready_o), 128'(sram_gnt_i && room));
                chk("sram_req",  128'(sram_req_o), 128'(req_valid_i && room));
                if (sram_req_o)
                    chk("cmd_pass", 128'({sram_we_o, sram_addr_o, sram_be_o, sram_wdata_o}),
                                    128'({req_we_i, req_addr_i, req_be_i, req_wdata_i}));
                chk("rsp_valid", 128'(rsp_valid_o), 128'(head_due));
                if (rsp_valid_o && head_due) chk("rsp_rdata", 128'(rsp_rdata_o), 128'(sb[0].data));
                chk("busy", 128'(busy_o), 128'(sb.size() != 0));
                chk("err_cnt", 128'(err_cnt_o), 128'(exp_err()));
                if (rsp_valid_o && rsp_ready_i && (sb.size() != 0)) void'(sb.pop_front());
                if (sram_single_err_i) err_pulses++;
            end
        end
    end

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    task automatic start_req(input bit we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [BW-1:0] be);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = a;
        req_wdata_i = d;
        req_be_i    = be;
    endtask

    // Wait for the pending request to be accepted; on acceptance update the reference
    task automatic wait_acc(input int unsigned budget, output bit ok, output int unsigned acc);
        ok  = 1'b0;
        acc = 0;
        for (int unsigned n = 0; n < budget; n++) begin
            @(negedge clk_i);
            if (req_ready_o && !rst_i) begin
                ok  = 1'b1;
                acc = cyc;
                break;
            end
        end
        @(posedge clk_i);
        #1;
        if (ok) begin
            if (req_we_i) begin
                for (int unsigned b = 0; b < BW; b++) begin
                    if (req_be_i[b]) ref_mem[req_addr_i][8*b +: 8] = req_wdata_i[8*b +: 8];
                end
            end else begin
                sb.push_back('{data: ref_mem[req_addr_i], due: acc + LAT + 1});
            end
            #1;
            req_valid_i = 1'b0;
        end else begin
            #1;
        end
    endtask

    task automatic do_req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [BW-1:0] be, input int unsigned budget,
                          output int unsigned acc);
        bit ok;
        start_req(we, a, d, be);
        wait_acc(budget, ok, acc);
        if (!ok) begin
            fail_bound("accept_timeout", budget);
            req_valid_i = 1'b0;
        end
    endtask

    initial begin
        bit          ok;
        int unsigned t;
        int unsigned p;
        int unsigned first;
        int unsigned last;
        bit          drained;

        rst_i       = 1'b0;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_be_i    = '0;
        #1 rst_i = 1'b1;
        idle(3);
        rst_i = 1'b0;

        // Fill both memories through the DUT
        for (int unsigned a = 0; a < 2**AW; a++)
            do_req(1'b1, AW'(a), {$urandom, $urandom}, '1, 10, t);

        // Single read after write
        do_req(1'b1, AW'(5), {8{8'hA5}}, '1, 10, t);
        do_req(1'b0, AW'(5), '0, '0, 10, t);
        idle(4);

        // Streaming reads, one per cycle
        for (int unsigned i = 0; i < 16; i++) begin
            do_req(1'b0, AW'(i), '0, '0, 10, t);
            if (i == 0) first = t;
            last = t;
        end
        chk("stream_span", 128'(last - first), 128'(15));
        idle(5);

        // Backpressure: four reads fill all credits, writes still pass
        dir_rdy = 1'b0;
        idle(1);
        for (int unsigned i = 0; i < 4; i++) do_req(1'b0, AW'(i + 8), '0, '0, 10, t);
        do_req(1'b1, AW'(2), {$urandom, $urandom}, 8'h0F, 10, t);
        start_req(1'b0, AW'(2), '0, '0);
        wait_acc(4, ok, t);
        chk("bp_blocked", 128'(ok), 128'(0));
        p       = cyc;
        dir_rdy = 1'b1;
        wait_acc(20, ok, t);
        chk("bp_accept", 128'(ok), 128'(1));
        chk("bp_next_read", 128'(t - p), 128'(1));
        req_valid_i = 1'b0;
        idle(6);

        // Grant stall: request held without grant
        dir_gnt = 1'b0;
        start_req(1'b0, AW'(3), '0, '0);
        wait_acc(3, ok, t);
        chk("gnt_stall", 128'(ok), 128'(0));
        p       = cyc;
        dir_gnt = 1'b1;
        wait_acc(5, ok, t);
        chk("gnt_accept", 128'(ok), 128'(1));
        chk("gnt_cycle", 128'(t - p), 128'(0));
        req_valid_i = 1'b0;
        idle(4);

        // Reset one cycle after a read is accepted
        do_req(1'b0, AW'(9), '0, '0, 10, t);
        rst_i = 1'b1;
        idle(2);
        rst_i = 1'b0;
        idle(6);

        // Random traffic with random grant and consumer backpressure
        rand_en = 1'b1;
        for (int unsigned i = 0; i < 300; i++) begin
            do_req($urandom_range(0, 2) == 0, AW'($urandom), {$urandom, $urandom},
                   BW'($urandom), 100, t);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_en = 1'b0;
        dir_rdy = 1'b1;
        dir_gnt = 1'b1;

        drained = 1'b0;
        for (int unsigned n = 0; n < 200; n++) begin
            if (sb.size() == 0) begin
                drained = 1'b1;
                break;
            end
            @(posedge clk_i);
        end
        if (!drained) fail_bound("drain_timeout", 200);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_llc_sram_req_ctrl.md
# axi_llc_sram_req_ctrl

Request controller that sits directly upstream of an LLC SRAM macro (tag or data array). It accepts a valid/ready request stream from the LLC pipeline and drives the SRAM's req/gnt port, tracking read latency and capturing read data. Read data is returned as a valid/ready response stream. Credit-based flow control guarantees that no read is issued unless response storage is reserved for it.

## Interface
Parameters:
- AddrWidth, 10, SRAM word address width
- DataWidth, 128, data width
- BeWidth, DataWidth/8, byte-enable width
- Latency, 1, SRAM read latency in cycles (>= 1)
- RspDepth, 4, response FIFO depth; must be >= Latency+1, full read throughput needs >= Latency+2
- ErrCntWidth, 16, error counter width

Ports:
- clk_i in 1 clock
- rst_i in 1 asynchronous reset, active-high
- req_valid_i in 1 request valid
- req_ready_o out 1 request accepted when valid&ready
- req_we_i in 1 1 = write, 0 = read
- req_addr_i in AddrWidth word address
- req_wdata_i in DataWidth write data
- req_be_i in BeWidth write byte enable
- rsp_valid_o out 1 read data valid
- rsp_ready_i in 1 consumer ready
- rsp_rdata_o out DataWidth read data
- sram_req_o out 1 SRAM request
- sram_we_o / sram_addr_o / sram_wdata_o / sram_be_o out 1/AddrWidth/DataWidth/BeWidth, SRAM command
- sram_gnt_i in 1 SRAM grant
- sram_rdata_i in DataWidth SRAM read data
- sram_single_err_i in 1 SRAM corrected-error pulse
- err_cnt_o out ErrCntWidth saturating corrected-error count
- busy_o out 1 reads in flight or FIFO non-empty

## Operation
- Credits: `free = RspDepth - fifo_cnt - inflight_cnt`, computed from registered state only.
- Read eligible iff `free > 0`. Write is always eligible.
- `sram_req_o = req_valid_i & eligible`. Command fields pass through combinationally.
- `req_ready_o = sram_gnt_i & eligible`. A transfer happens when `sram_req_o & sram_gnt_i`.
- Accepted read pushes a 1 into a Latency-deep valid shift register and increments inflight_cnt.
- When the bit exits the shift register, `sram_rdata_i` is written into the FIFO and inflight_cnt decrements.
- FIFO pop on `rsp_valid_o & rsp_ready_i`; `rsp_valid_o = fifo_cnt != 0`.
- Push and pop in the same cycle: fifo_cnt unchanged, data order preserved.
- A pop frees its credit from the next cycle on. There is no combinational path from rsp_ready_i to req_ready_o.
- Writes never occupy credits or FIFO entries.
- FIFO overflow is impossible by construction. An assertion checks `fifo_cnt + inflight_cnt <= RspDepth`.
- busy_o = `inflight_cnt != 0 | fifo_cnt != 0`.

## Timing
- Reset values: req_ready_o 0 only if sram_gnt_i is 0, otherwise follows the rule above; rsp_valid_o 0; rsp_rdata_o 0; busy_o 0; err_cnt_o 0. The shift register, counters and FIFO pointers reset to 0.
- Read accepted in cycle t: SRAM data is sampled at the end of cycle t+Latency, and rsp_valid_o rises in cycle t+Latency+1.
- Back-to-back reads at one per cycle are sustained when RspDepth >= Latency+2 and rsp_ready_i is held at 1.
- A request held without grant stays pending. Requester fields must remain stable until accepted (valid/ready rule).
- Reset mid-operation discards in-flight reads and FIFO contents. Data returned after reset is ignored.
- Counters wrap FIFO pointers modulo RspDepth. err_cnt_o saturates at all-ones.

## Configuration
- Macro `AXI_LLC_SRAM_REQ_CTRL_ERR_CNT_EN`.
- Defined: err_cnt_o increments by 1 per cycle in which sram_single_err_i=1, saturating, cleared only by reset.
- Undefined: counter logic is not compiled, and err_cnt_o is tied to 0.

## Test plan
- Single read: write addr 5 = 0xA5A5…, then read addr 5 with gnt=1 and Latency=1 -> rsp_valid_o high exactly 2 cycles after read acceptance, rdata 0xA5A5….
- Streaming: 16 reads to addrs 0–15 with rsp_ready_i=1, RspDepth=4, Latency=1 -> req_ready_o stays 1 and 16 in-order responses arrive on consecutive cycles.
- Backpressure: rsp_ready_i=0 while issuing reads, RspDepth=4 -> exactly 4 reads accepted, req_ready_o=0 for reads, writes still accepted. Raising rsp_ready_i drains in order, and the next read is accepted one cycle after the first pop.
- Grant stall: sram_gnt_i=0 for 3 cycles with a pending read -> no acceptance, command stable. Accepted in the cycle gnt rises.
- Reset mid-flight: assert rst_i one cycle after a read is accepted -> after release rsp_valid_o=0, busy_o=0, and no stale response appears.
- Error counter with macro defined: 5 single_err pulses -> err_cnt_o=5; with ErrCntWidth=2, 5 pulses -> 3. Macro undefined -> err_cnt_o=0.
